mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the core's single data-memory port between the instruction fetch unit (read-only) and the load/store unit (read/write with byte mask).
- Sits between IFU/LSU and the memory bridge that calls the pmem DPI functions; one transaction outstanding at a time.
- Holds the request payload stable until the memory port accepts it, then routes the response back to the owning requester.

Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, read/write data width
- MASK_W, 8, byte-mask width (DATA_W/8)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset (reset==0 resets on rising clock)
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_req_addr  in  ADDR_W  fetch address
- ifu_resp_valid  out  1  one-cycle pulse, fetch data valid
- ifu_resp_data  out  DATA_W  fetch data
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_req_addr  in  ADDR_W  access address
- lsu_req_wen  in  1  1=write, 0=read
- lsu_req_wdata  in  DATA_W  store data
- lsu_req_mask  in  MASK_W  byte mask
- lsu_resp_valid  out  1  one-cycle pulse, load data / store ack
- lsu_resp_data  out  DATA_W  load data; 0 for stores
- mem_req_valid  out  1  request to memory bridge
- mem_req_ready  in  1  bridge accepts request
- mem_req_addr / mem_req_wen / mem_req_wdata / mem_req_mask  out  ADDR_W/1/DATA_W/MASK_W  registered payload
- mem_resp_valid  in  1  bridge response
- mem_resp_data  in  DATA_W  bridge read data
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, REQ, WAIT.
- Reset (reset==0): state=IDLE, owner=IFU, all mem_req_* and *_resp_* outputs 0, busy=0. Reset mid-transaction drops it; no response is ever delivered for it.
- IDLE:
  - Grant goes to lsu if lsu_req_valid, else ifu if ifu_req_valid (fixed LSU priority).
  - *_req_ready is combinational, asserted only for the granted requester, only in IDLE.
  - On handshake, latch payload and owner, then go to REQ. IFU requests latch wen=0, mask=all ones, wdata=0.
- REQ:
  - mem_req_valid=1; payload is stable and driven from registers.
  - mem_req_ready=1 → WAIT. Otherwise stay in REQ, holding valid and payload.
- WAIT:
  - mem_req_valid=0.
  - On mem_resp_valid: owner's resp_valid=1 for that cycle only, then go to IDLE.
  - resp_data = mem_resp_data for reads, 0 for LSU writes. The non-owner's resp_valid stays 0.
- mem_resp_valid in IDLE or REQ is ignored.
- Response data is combinational pass-through; resp_valid is gated by state and owner.
- Minimum latency (ready and response both same-cycle):
  - cycle0: req handshake
  - cycle1: mem_req_valid with mem_req_ready
  - cycle2: mem_resp_valid → resp pulse
  - cycle3: IDLE, next grant possible
- Simultaneous IFU and LSU valid in IDLE: LSU wins; IFU must hold valid and is served next.
- A write with mask==0 is still issued and acknowledged.
- A requester may deassert valid while not ready; this has no effect.

Optional Feature:
- MEM_ARB_RR_EN defined: round-robin grant. A last_owner register is reset to IFU. On a conflict, the requester that did not own the last completed transaction wins. A single valid requester always wins.
- Undefined: fixed LSU priority as above, no last_owner register.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum (IDLE=2'd0, REQ=2'd1, WAIT=2'd2)
  - owner encoding (OWNER_IFU=1'b0, OWNER_LSU=1'b1)
  - MASK_ALL constant
- One natural sub-module, mem_arb_grant: combinational grant logic, with last_owner input used under MEM_ARB_RR_EN.
- Request latch and FSM stay in mem_arbiter.

Test Plan:
- Reset: hold reset=0 with both valids high → all readies, mem_req_valid, resp_valids and busy are 0; release → next-cycle grant to LSU.
- IFU read: ifu addr 0x80000000, mem_req_ready=1, mem_resp_data=0x00000013_00000297 → mem_req_valid at cycle1 with addr 0x80000000, wen=0, mask 0xFF; ifu_resp pulse with that data at cycle2; lsu_resp_valid stays 0.
- LSU store with backpressure: addr 0x80001000, wdata 0xDEADBEEF, mask 0x0F, mem_req_ready low 3 cycles → payload stable all 4 REQ cycles; lsu_resp_valid pulse with data 0.
- Conflict: IFU and LSU valid in the same IDLE cycle → LSU served first, IFU served immediately after. With MEM_ARB_RR_EN, a second conflict goes to IFU.
- Spurious response: mem_resp_valid=1 in IDLE and in REQ → no resp pulse, state unchanged.
- Mid-operation reset: reset=0 during WAIT → IDLE next cycle, no resp_valid; a later mem_resp_valid is ignored.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arb_pkg                                                              |
// | Shared state, owner and mask definitions for the memory-port arbiter.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  localparam logic OWNER_IFU = 1'b0;
  localparam logic OWNER_LSU = 1'b1;

  // Wide enough for any supported mask width; users slice the low MASK_W bits.
  localparam logic [63:0] MASK_ALL = '1;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arb_grant.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arb_grant                                                            |
// | Combinational grant selection between IFU and LSU requesters.            |
// | MEM_ARB_RR_EN: round-robin on conflict, else fixed LSU priority.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic i_ifu_valid,
  input  logic i_lsu_valid,
`ifdef MEM_ARB_RR_EN
  input  logic i_last_owner,
`endif
  output logic o_grant_valid,
  output logic o_grant_owner
);

  always_comb begin
    o_grant_valid = i_ifu_valid | i_lsu_valid;
    o_grant_owner = OWNER_IFU;
    if (i_ifu_valid && i_lsu_valid) begin
`ifdef MEM_ARB_RR_EN
      // The requester that did not own the last completed transfer wins.
      o_grant_owner = (i_last_owner == OWNER_LSU) ? OWNER_IFU : OWNER_LSU;
`else
      o_grant_owner = OWNER_LSU;
`endif
    end else if (i_lsu_valid) begin
      o_grant_owner = OWNER_LSU;
    end
  end

endmodule : mem_arb_grant
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arbiter                                                              |
// | Shares one data-memory port between IFU (read) and LSU (read/write).     |
// | MEM_ARB_RR_EN: round-robin grant on conflict (default: LSU priority).    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int MASK_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_req_addr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_resp_data,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic              lsu_req_wen,
  input  logic [DATA_W-1:0] lsu_req_wdata,
  input  logic [MASK_W-1:0] lsu_req_mask,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_resp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [MASK_W-1:0] mem_req_mask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              busy
);

  state_e              r_state;
  state_e              w_next_state;
  logic                r_owner;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wen;
  logic [DATA_W-1:0]   r_wdata;
  logic [MASK_W-1:0]   r_mask;
  logic                w_grant_valid;
  logic                w_grant_owner;
  logic                w_req_fire;

`ifdef MEM_ARB_RR_EN
  logic                r_last_owner;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_last_owner <= OWNER_IFU;
    end else if (r_state == WAIT && mem_resp_valid) begin
      r_last_owner <= r_owner;
    end
  end
`endif

  mem_arb_grant u_grant (
    .i_ifu_valid   (ifu_req_valid),
    .i_lsu_valid   (lsu_req_valid),
`ifdef MEM_ARB_RR_EN
    .i_last_owner  (r_last_owner),
`endif
    .o_grant_valid (w_grant_valid),
    .o_grant_owner (w_grant_owner)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    case (r_state)
      IDLE: begin
        // Readies are masked by reset so nothing is accepted while held in reset.
        if (reset && w_grant_valid) begin
          ifu_req_ready = (w_grant_owner == OWNER_IFU);
          lsu_req_ready = (w_grant_owner == OWNER_LSU);
          w_next_state  = REQ;
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          w_next_state = WAIT;
        end
      end
      WAIT: begin
        if (mem_resp_valid) begin
          ifu_resp_valid = (r_owner == OWNER_IFU);
          lsu_resp_valid = (r_owner == OWNER_LSU);
          w_next_state   = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign w_req_fire = ifu_req_ready | lsu_req_ready;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_owner <= OWNER_IFU;
      r_addr  <= '0;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_mask  <= '0;
    end else if (w_req_fire) begin
      r_owner <= w_grant_owner;
      if (w_grant_owner == OWNER_LSU) begin
        r_addr  <= lsu_req_addr;
        r_wen   <= lsu_req_wen;
        r_wdata <= lsu_req_wdata;
        r_mask  <= lsu_req_mask;
      end else begin
        r_addr  <= ifu_req_addr;
        r_wen   <= 1'b0;
        r_wdata <= '0;
        r_mask  <= MASK_ALL[MASK_W-1:0];
      end
    end
  end

  assign mem_req_valid = (r_state == REQ);
  assign mem_req_addr  = r_addr;
  assign mem_req_wen   = r_wen;
  assign mem_req_wdata = r_wdata;
  assign mem_req_mask  = r_mask;
  assign busy          = (r_state != IDLE);

  // Data is zero outside the response pulse and for store acknowledgements.
  assign ifu_resp_data = ifu_resp_valid ? mem_resp_data : '0;
  assign lsu_resp_data = (lsu_resp_valid && !r_wen) ? mem_resp_data : '0;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_arbiter                                                           |
// | Directed self-checking bench for mem_arbiter.                            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mem_arbiter;

  logic        clock;
  logic        reset;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [63:0] ifu_req_addr;
  logic        ifu_resp_valid;
  logic [63:0] ifu_resp_data;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [63:0] lsu_req_addr;
  logic        lsu_req_wen;
  logic [63:0] lsu_req_wdata;
  logic [7:0]  lsu_req_mask;
  logic        lsu_resp_valid;
  logic [63:0] lsu_resp_data;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_req_wen;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_mask;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MASK_W(8)) dut (
    .clock          (clock),
    .reset          (reset),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_req_addr   (ifu_req_addr),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_resp_data  (ifu_resp_data),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_req_addr   (lsu_req_addr),
    .lsu_req_wen    (lsu_req_wen),
    .lsu_req_wdata  (lsu_req_wdata),
    .lsu_req_mask   (lsu_req_mask),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_resp_data  (lsu_resp_data),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wen    (mem_req_wen),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_mask   (mem_req_mask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic cyc();
    @(negedge clock);
  endtask

  initial begin
    reset          = 1'b0;
    ifu_req_valid  = 1'b1;
    ifu_req_addr   = 64'h8000_0000;
    lsu_req_valid  = 1'b1;
    lsu_req_addr   = 64'h8000_1000;
    lsu_req_wen    = 1'b1;
    lsu_req_wdata  = 64'hDEAD_BEEF;
    lsu_req_mask   = 8'h0F;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 64'h0;

    // Held in reset with both requesters valid
    cyc(); cyc(); #1;
    chk1("rst_ifu_ready", ifu_req_ready, 1'b0);
    chk1("rst_lsu_ready", lsu_req_ready, 1'b0);
    chk1("rst_mem_valid", mem_req_valid, 1'b0);
    chk1("rst_ifu_resp", ifu_resp_valid, 1'b0);
    chk1("rst_lsu_resp", lsu_resp_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk64("rst_mem_addr", mem_req_addr, 64'h0);

    // Release: conflict, LSU store wins
    cyc(); reset = 1'b1; #1;
    chk1("conf_lsu_ready", lsu_req_ready, 1'b1);
    chk1("conf_ifu_ready", ifu_req_ready, 1'b0);

    // REQ cycle 1 with spurious response and backpressure
    cyc(); lsu_req_valid = 1'b0; lsu_req_addr = 64'h0; lsu_req_wdata = 64'h0;
    mem_resp_valid = 1'b1; mem_resp_data = 64'h55; #1;
    chk1("st_req_valid1", mem_req_valid, 1'b1);
    chk64("st_addr1", mem_req_addr, 64'h8000_1000);
    chk1("st_wen1", mem_req_wen, 1'b1);
    chk64("st_wdata1", mem_req_wdata, 64'hDEAD_BEEF);
    chk64("st_mask1", {56'h0, mem_req_mask}, 64'h0F);
    chk1("st_busy1", busy, 1'b1);
    chk1("st_ifu_ready_busy", ifu_req_ready, 1'b0);
    chk1("spur_req_lsu_resp", lsu_resp_valid, 1'b0);
    chk1("spur_req_ifu_resp", ifu_resp_valid, 1'b0);

    cyc(); mem_resp_valid = 1'b0; #1;
    chk1("st_req_valid2", mem_req_valid, 1'b1);
    chk64("st_addr2", mem_req_addr, 64'h8000_1000);
    chk64("st_wdata2", mem_req_wdata, 64'hDEAD_BEEF);
    cyc(); #1;
    chk1("st_req_valid3", mem_req_valid, 1'b1);
    chk64("st_mask3", {56'h0, mem_req_mask}, 64'h0F);
    cyc(); mem_req_ready = 1'b1; #1;
    chk1("st_req_valid4", mem_req_valid, 1'b1);
    chk64("st_addr4", mem_req_addr, 64'h8000_1000);
    chk64("st_wdata4", mem_req_wdata, 64'hDEAD_BEEF);

    // WAIT
    cyc(); mem_req_ready = 1'b0; #1;
    chk1("st_wait_valid", mem_req_valid, 1'b0);
    chk1("st_wait_busy", busy, 1'b1);
    chk1("st_wait_noresp", lsu_resp_valid, 1'b0);
    cyc(); mem_resp_valid = 1'b1; mem_resp_data = 64'h1234; #1;
    chk1("st_resp_valid", lsu_resp_valid, 1'b1);
    chk64("st_resp_data", lsu_resp_data, 64'h0);
    chk1("st_ifu_resp", ifu_resp_valid, 1'b0);
    chk1("st_wait_ifu_ready", ifu_req_ready, 1'b0);

    // IFU served right after
    cyc(); mem_resp_valid = 1'b0; #1;
    chk1("st_resp_pulse_end", lsu_resp_valid, 1'b0);
    chk1("if_ready", ifu_req_ready, 1'b1);
    chk1("if_idle_busy", busy, 1'b0);
    cyc(); ifu_req_valid = 1'b0; ifu_req_addr = 64'h0; mem_req_ready = 1'b1; #1;
    chk1("if_req_valid", mem_req_valid, 1'b1);
    chk64("if_addr", mem_req_addr, 64'h8000_0000);
    chk1("if_wen", mem_req_wen, 1'b0);
    chk64("if_mask", {56'h0, mem_req_mask}, 64'hFF);
    chk64("if_wdata", mem_req_wdata, 64'h0);
    cyc(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1;
    mem_resp_data = 64'h0000_0013_0000_0297; #1;
    chk1("if_resp_valid", ifu_resp_valid, 1'b1);
    chk64("if_resp_data", ifu_resp_data, 64'h0000_0013_0000_0297);
    chk1("if_lsu_resp", lsu_resp_valid, 1'b0);
    cyc(); mem_resp_valid = 1'b0; #1;
    chk1("if_resp_pulse_end", ifu_resp_valid, 1'b0);
    chk1("if_done_busy", busy, 1'b0);

    // Spurious response in IDLE
    cyc(); mem_resp_valid = 1'b1; mem_resp_data = 64'h99; #1;
    chk1("spur_idle_ifu", ifu_resp_valid, 1'b0);
    chk1("spur_idle_lsu", lsu_resp_valid, 1'b0);
    cyc(); mem_resp_valid = 1'b0; #1;
    chk1("spur_idle_busy", busy, 1'b0);

    // LSU read, leaves LSU as last owner
    lsu_req_valid = 1'b1; lsu_req_wen = 1'b0; lsu_req_addr = 64'h100; lsu_req_mask = 8'h03; #1;
    chk1("rd_lsu_ready", lsu_req_ready, 1'b1);
    cyc(); lsu_req_valid = 1'b0; mem_req_ready = 1'b1; #1;
    chk1("rd_wen", mem_req_wen, 1'b0);
    chk64("rd_addr", mem_req_addr, 64'h100);
    cyc(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 64'hCAFE; #1;
    chk1("rd_resp_valid", lsu_resp_valid, 1'b1);
    chk64("rd_resp_data", lsu_resp_data, 64'hCAFE);

    // Second conflict
    cyc(); mem_resp_valid = 1'b0;
    ifu_req_valid = 1'b1; ifu_req_addr = 64'h200;
    lsu_req_valid = 1'b1; lsu_req_addr = 64'h300; #1;
`ifdef MEM_ARB_RR_EN
    chk1("conf2_ifu_ready", ifu_req_ready, 1'b1);
    chk1("conf2_lsu_ready", lsu_req_ready, 1'b0);
`else
    chk1("conf2_ifu_ready", ifu_req_ready, 1'b0);
    chk1("conf2_lsu_ready", lsu_req_ready, 1'b1);
`endif
    cyc(); ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_req_ready = 1'b1; #1;
`ifdef MEM_ARB_RR_EN
    chk64("conf2_addr", mem_req_addr, 64'h200);
`else
    chk64("conf2_addr", mem_req_addr, 64'h300);
`endif

    // Reset during WAIT
    cyc(); mem_req_ready = 1'b0; reset = 1'b0; #1;
    chk1("mid_wait_busy", busy, 1'b1);
    cyc(); reset = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 64'hBAD; #1;
    chk1("mid_busy", busy, 1'b0);
    chk1("mid_ifu_resp", ifu_resp_valid, 1'b0);
    chk1("mid_lsu_resp", lsu_resp_valid, 1'b0);
    chk1("mid_mem_valid", mem_req_valid, 1'b0);
    chk64("mid_mem_addr", mem_req_addr, 64'h0);
    cyc(); mem_resp_valid = 1'b0; #1;
    chk1("mid_after_busy", busy, 1'b0);

    // Store with empty mask is still issued and acknowledged
    lsu_req_valid = 1'b1; lsu_req_wen = 1'b1; lsu_req_addr = 64'h400;
    lsu_req_wdata = 64'h5; lsu_req_mask = 8'h00; #1;
    chk1("m0_ready", lsu_req_ready, 1'b1);
    cyc(); lsu_req_valid = 1'b0; mem_req_ready = 1'b1; #1;
    chk1("m0_req_valid", mem_req_valid, 1'b1);
    chk64("m0_mask", {56'h0, mem_req_mask}, 64'h0);
    cyc(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 64'h77; #1;
    chk1("m0_resp_valid", lsu_resp_valid, 1'b1);
    chk64("m0_resp_data", lsu_resp_data, 64'h0);
    cyc(); mem_resp_valid = 1'b0; #1;
    chk1("m0_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mem_arbiter
`default_nettype wire
